reorder_addr_gen: RTL and testbench
===================================

// Module: reorder_addr_gen
// PURPOSE
//  Parametrised reorder-memory address generator for the FFT output reorder stage.
//  - Starts on an external valid pulse; walks DEPTH addresses in linear or digit-reversed order.
//  - Supports stall (enable), ping-pong bank select and a frame-done pulse.
//  - Runs single-shot, re-armable or continuous multi-frame.
//  - Drives the reorder RAM address and write-enable path behind the last butterfly stage.
// PARAMETERS
//  ADDR_W      12    address width; rema_o width
//  DEPTH       4096  addresses per frame; 2 <= DEPTH <= 2**ADDR_W
//  DIG_W       4     digit width for reversal (4 = radix-16, 1 = bit-reverse); ADDR_W % DIG_W == 0
//  FRAME_MODE  0     0 single-shot, sticky DONE; 1 re-armable, DONE->IDLE; 2 continuous wrap
// PORTS
//  clk           in   1       clock, rising edge
//  rst_n         in   1       reset, asynchronous, active-low
//  start_i       in   1       frame start request (external valid)
//  en_i          in   1       advance enable; 0 = stall
//  mode_i        in   1       0 linear, 1 digit-reversed; sampled at start and at wrap
//  rema_o        out  ADDR_W  reorder memory address
//  rema_vld_o    out  1       address consumed this cycle
//  bank_o        out  1       ping-pong bank select
//  frame_done_o  out  1       one-cycle pulse after the last address of a frame
//  busy_o        out  1       state == WORK
// BEHAVIOUR
//  Reset (async): state=IDLE, cnt=0, mode_q=0, bank_o=0, frame_done_o=0. All outputs read 0.
//  States:
//   - IDLE -> WORK when start_i=1; latch mode_q<=mode_i; cnt=0.
//   - WORK: cnt<=cnt+1 when en_i=1; cnt holds when en_i=0.
//     Last address = (cnt==DEPTH-1 && en_i). On last address:
//     cnt<=0, bank_o toggles, frame_done_o=1 in the next cycle.
//     Next state: FRAME_MODE 0 or 1 -> DONE; FRAME_MODE 2 -> stay in WORK, mode_q<=mode_i.
//   - DONE: FRAME_MODE 0 sticky until reset; FRAME_MODE 1 -> IDLE on the next cycle.
//  Outputs (combinational from registers):
//   - rema_o = mode_q ? digrev(cnt) : cnt.
//   - rema_vld_o = (state==WORK) & en_i.
//   - rema_o = 0 outside WORK.
//  digrev: reverse the order of the ADDR_W/DIG_W digits; bits inside each digit are not reversed.
//   - Reversal is legal only when DEPTH == 2**ADDR_W.
//   - Otherwise mode_q is forced to 0 at latch time.
//  Latency: start_i high at cycle t -> first address (cnt=0) at t+1.
//   - With no stall, frame_done_o is high at cycle t+DEPTH+1.
//  Counter width: ADDR_W bits; compare against DEPTH-1 only, so cnt never exceeds DEPTH-1.
//  Boundary conditions:
//   - start_i while in WORK or DONE: ignored, in all modes.
//   - start_i in the same cycle as the last address (FRAME_MODE 1): ignored; a new start is accepted only in IDLE.
//   - en_i=0 on the last address: frame does not end until en_i=1.
//   - mode_i change mid-frame: no effect until the next latch point.
//   - rst_n low mid-frame: immediate return to the reset values; a following start restarts at cnt=0, bank 0.
// STRUCTURE
//  Package reorder_pkg:
//   - state encoding: IDLE=2'd0, WORK=2'd1, DONE=2'd2 (2'd3 unused, decodes to IDLE).
//   - FRAME_MODE constants: FM_SINGLE=0, FM_REARM=1, FM_CONT=2.
//  Sub-module digit_reverse #(ADDR_W, DIG_W): purely combinational generate-based permutation.
//  Top level: FSM, counter, bank and done registers, output muxing.
// TESTING
//  1. FRAME_MODE 0, mode_i=0, en_i=1, start pulse -> rema_o 0..4095 over 4096 cycles;
//     frame_done_o high at start+4097; then DONE, rema_vld_o=0, further starts ignored.
//  2. mode_i=1 (DIG_W=4) -> cnt 0x001 gives rema_o 0x100; cnt 0x123 gives 0x321; cnt 0x010 gives 0x010.
//  3. en_i low at cnt=5 for 3 cycles -> rema_o holds 5, rema_vld_o=0; then resumes at 6; frame_done_o delayed 3 cycles.
//  4. FRAME_MODE 2, two frames, mode_i toggled at cnt=1000 -> bank_o goes 0->1->0 at the wraps;
//     new mode takes effect only from the second frame's cnt=0; busy_o stays 1.
//  5. rst_n low at cnt=100 -> rema_o, bank_o, busy_o go 0 asynchronously; restart begins at 0, bank 0.
//  6. FRAME_MODE 1 -> start during WORK is ignored; after frame_done_o, DONE then IDLE;
//     second start yields a full frame with bank_o=1.

Source files
------------

// File: rtl/reorder_pkg.sv
// Shared types and frame-mode constants for the FFT output reorder address generator.
package reorder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WORK = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned FM_SINGLE = 0;
  localparam int unsigned FM_REARM  = 1;
  localparam int unsigned FM_CONT   = 2;

endpackage

// File: rtl/reorder_addr_gen_digrev.sv
// Digit-reversal permutation: reverses the order of DIG_W-bit digits of an address,
// leaving bit order inside each digit untouched.
module digit_reverse #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DIG_W  = 4
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] rev
);

  localparam int unsigned NDIG = ADDR_W / DIG_W;

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    assign rev[i*DIG_W +: DIG_W] = addr[(NDIG-1-i)*DIG_W +: DIG_W];
  end

endmodule

// File: rtl/reorder_addr_gen.sv
// Reorder-memory address generator: walks DEPTH addresses per frame in linear or
// digit-reversed order, with stall, ping-pong bank select and frame-done pulse.
module reorder_addr_gen
  import reorder_pkg::*;
#(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned DIG_W      = 4,
  parameter int unsigned FRAME_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              en_i,
  input  logic              mode_i,
  output logic [ADDR_W-1:0] rema_o,
  output logic              rema_vld_o,
  output logic              bank_o,
  output logic              frame_done_o,
  output logic              busy_o
);

  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);
  // Reversal only makes sense when the frame fills the whole address space.
  localparam logic              REV_OK = (DEPTH == 2**ADDR_W);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt, rev;
  logic              mode_q, mode_nxt, bank_nxt, done_nxt;

  digit_reverse #(
    .ADDR_W (ADDR_W),
    .DIG_W  (DIG_W)
  ) u_digrev (
    .addr (cnt),
    .rev  (rev)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mode_nxt  = mode_q;
    bank_nxt  = bank_o;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_nxt = WORK;
          cnt_nxt   = '0;
          mode_nxt  = mode_i & REV_OK;
        end
      end
      WORK: begin
        if (en_i) begin
          if (cnt == LAST) begin
            cnt_nxt  = '0;
            bank_nxt = ~bank_o;
            done_nxt = 1'b1;
            if (FRAME_MODE == FM_CONT) mode_nxt  = mode_i & REV_OK;
            else                       state_nxt = DONE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      DONE: begin
        if (FRAME_MODE == FM_REARM) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      mode_q       <= 1'b0;
      bank_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      mode_q       <= mode_nxt;
      bank_o       <= bank_nxt;
      frame_done_o <= done_nxt;
    end
  end

  assign busy_o     = (state == WORK);
  assign rema_vld_o = busy_o & en_i;
  assign rema_o     = busy_o ? (mode_q ? rev : cnt) : '0;

endmodule

// File: tb/tb_reorder_addr_gen.sv
// Scoreboard bench for reorder_addr_gen across all frame modes and several geometries.
module tb_reorder_addr_gen;

  typedef struct {
    int unsigned addr;
    logic        bank;
    logic        last;
  } item_t;

  typedef enum int {M_IDLE, M_WORK, M_DONE} mstate_t;

  localparam int unsigned NDUT = 5;
  int unsigned p_aw    [NDUT] = '{12, 12, 12, 8, 6};
  int unsigned p_depth [NDUT] = '{4096, 4096, 4096, 200, 64};
  int unsigned p_dw    [NDUT] = '{4, 4, 4, 1, 2};
  int unsigned p_fm    [NDUT] = '{0, 1, 2, 1, 2};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a [NDUT];
  logic        en_a    [NDUT];
  logic        mode_a  [NDUT];
  logic [11:0] rema_a  [NDUT];
  logic        vld_a   [NDUT];
  logic        bank_a  [NDUT];
  logic        done_a  [NDUT];
  logic        busy_a  [NDUT];
  logic [7:0]  rema3;
  logic [5:0]  rema4;

  int          sel = 0;
  logic [11:0] rema_s;
  logic        vld_s, bank_s, done_s, busy_s;

  item_t       sbq[$];
  mstate_t     mst   = M_IDLE;
  int unsigned mpos  = 0;
  logic        mbank = 1'b0;
  logic        exp_busy = 1'b0;
  logic        exp_vld  = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  reorder_addr_gen #(.ADDR_W(12), .DEPTH(4096), .DIG_W(4), .FRAME_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start_a[0]), .en_i(en_a[0]), .mode_i(mode_a[0]),
    .rema_o(rema_a[0]), .rema_vld_o(vld_a[0]), .bank_o(bank_a[0]),
    .frame_done_o(done_a[0]), .busy_o(busy_a[0]));
  reorder_addr_gen #(.ADDR_W(12), .DEPTH(4096), .DIG_W(4), .FRAME_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start_a[1]), .en_i(en_a[1]), .mode_i(mode_a[1]),
    .rema_o(rema_a[1]), .rema_vld_o(vld_a[1]), .bank_o(bank_a[1]),
    .frame_done_o(done_a[1]), .busy_o(busy_a[1]));
  reorder_addr_gen #(.ADDR_W(12), .DEPTH(4096), .DIG_W(4), .FRAME_MODE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(start_a[2]), .en_i(en_a[2]), .mode_i(mode_a[2]),
    .rema_o(rema_a[2]), .rema_vld_o(vld_a[2]), .bank_o(bank_a[2]),
    .frame_done_o(done_a[2]), .busy_o(busy_a[2]));
  reorder_addr_gen #(.ADDR_W(8), .DEPTH(200), .DIG_W(1), .FRAME_MODE(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .start_i(start_a[3]), .en_i(en_a[3]), .mode_i(mode_a[3]),
    .rema_o(rema3), .rema_vld_o(vld_a[3]), .bank_o(bank_a[3]),
    .frame_done_o(done_a[3]), .busy_o(busy_a[3]));
  reorder_addr_gen #(.ADDR_W(6), .DEPTH(64), .DIG_W(2), .FRAME_MODE(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .start_i(start_a[4]), .en_i(en_a[4]), .mode_i(mode_a[4]),
    .rema_o(rema4), .rema_vld_o(vld_a[4]), .bank_o(bank_a[4]),
    .frame_done_o(done_a[4]), .busy_o(busy_a[4]));

  assign rema_a[3] = {4'b0, rema3};
  assign rema_a[4] = {6'b0, rema4};

  always_comb begin
    rema_s = rema_a[sel];
    vld_s  = vld_a[sel];
    bank_s = bank_a[sel];
    done_s = done_a[sel];
    busy_s = busy_a[sel];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (dut %0d, t=%0t)", name, act, exp, sel, $time);
    end
  endtask

  // Reference reversal: peel digits off the bottom, stack them on the top.
  function automatic int unsigned ref_digrev(input int unsigned k, input int unsigned aw,
                                             input int unsigned dw);
    int unsigned radix = 1 << dw;
    int unsigned x = k;
    int unsigned r = 0;
    for (int unsigned i = 0; i < aw / dw; i++) begin
      r = r * radix + x % radix;
      x = x / radix;
    end
    return r;
  endfunction

  task automatic push_frame(input logic m);
    item_t       it;
    int unsigned dep = p_depth[sel];
    logic        rev = m && (dep == (1 << p_aw[sel]));
    for (int unsigned k = 0; k < dep; k++) begin
      it.addr = rev ? ref_digrev(k, p_aw[sel], p_dw[sel]) : k;
      it.bank = mbank;
      it.last = (k == dep - 1);
      sbq.push_back(it);
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < NDUT; i++) begin
      start_a[i] = 1'b0;
      en_a[i]    = 1'b0;
      mode_a[i]  = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, advance the frame model to the next edge, wait out the edge.
  task automatic step(input logic s, input logic e, input logic m);
    clear_inputs();
    start_a[sel] = s;
    en_a[sel]    = e;
    mode_a[sel]  = m;
    exp_busy = (mst == M_WORK);
    exp_vld  = exp_busy && e;
    case (mst)
      M_IDLE: if (s) begin
        mst  = M_WORK;
        mpos = 0;
        push_frame(m);
      end
      M_WORK: if (e) begin
        if (mpos == p_depth[sel] - 1) begin
          mbank = ~mbank;
          if (p_fm[sel] == 2) begin
            mpos = 0;
            push_frame(m);
          end else begin
            mst = M_DONE;
          end
        end else begin
          mpos++;
        end
      end
      M_DONE: if (p_fm[sel] == 1) mst = M_IDLE;
      default: mst = M_IDLE;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic reset_assert();
    rst_n = 1'b0;
    clear_inputs();
    sbq.delete();
    mst      = M_IDLE;
    mpos     = 0;
    mbank    = 1'b0;
    exp_busy = 1'b0;
    exp_vld  = 1'b0;
  endtask

  task automatic reset_release();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_random(input int unsigned n, input int unsigned p_start,
                            input int unsigned p_stall);
    for (int unsigned c = 0; c < n; c++) begin
      logic s, e, m;
      s = ($urandom_range(99) < p_start);
      // Starts on the last address and while DONE must both be ignored.
      if ((mst == M_WORK && mpos == p_depth[sel] - 1) || mst == M_DONE) s = 1'b1;
      e = ($urandom_range(99) >= p_stall);
      m = 1'($urandom_range(1));
      step(s, e, m);
    end
  endtask

  // Monitor: every cycle away from the clock edge, compare against the scoreboard.
  initial begin
    item_t it;
    logic  last_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_prev = 1'b0;
        check("reset_outputs", {rema_s, vld_s, bank_s, done_s, busy_s}, '0);
      end else begin
        check("busy", busy_s, exp_busy);
        check("vld", vld_s, exp_vld);
        check("frame_done", done_s, last_prev);
        last_prev = 1'b0;
        if (!exp_busy) begin
          check("addr_outside_work", rema_s, '0);
        end else if (sbq.size() == 0) begin
          check("addr_without_frame", 32'd1, 32'd0);
        end else begin
          it = sbq[0];
          check("addr", rema_s, it.addr);
          check("bank", bank_s, it.bank);
          if (vld_s) begin
            void'(sbq.pop_front());
            last_prev = it.last;
          end
        end
      end
    end
  end

  initial begin
    int unsigned k;
    int unsigned stalls;
    logic        s, e;

    reset_assert();
    clear_inputs();
    reset_release();

    // Single-shot: linear frame, 3-cycle stall at cnt 5, then sticky DONE.
    sel = 0;
    step(1'b1, 1'b1, 1'b0);
    k = 1;
    stalls = 0;
    while (!done_s && k < 6000) begin
      e = !(mst == M_WORK && mpos == 5 && stalls < 3);
      if (!e) stalls++;
      s = ($urandom_range(99) < 10);
      step(s, e, 1'($urandom_range(1)));
      k++;
    end
    check("done_latency", k, p_depth[0] + 1 + 3);
    run_random(300, 40, 10);

    // Re-armable: random stalls and start attempts over a couple of frames.
    reset_assert();
    sel = 1;
    reset_release();
    run_random(9500, 30, 5);

    // Continuous: reach cnt 100 of the second frame, then reset asynchronously.
    reset_assert();
    sel = 2;
    reset_release();
    step(1'b1, 1'b1, 1'b1);
    k = 0;
    while (!(mbank && mst == M_WORK && mpos == 100) && k < 12000) begin
      step(1'b0, ($urandom_range(99) >= 5), 1'($urandom_range(1)));
      k++;
    end
    check("reach_second_frame", (k < 12000), 1);
    #1;
    reset_assert();
    #1;
    check("async_rema", rema_s, '0);
    check("async_bank", bank_s, '0);
    check("async_busy", busy_s, '0);
    reset_release();
    run_random(4500, 20, 5);

    // Non power-of-two depth: reversal request must be ignored.
    reset_assert();
    sel = 3;
    reset_release();
    run_random(1200, 30, 10);

    // Small radix-4 continuous instance.
    reset_assert();
    sel = 4;
    reset_release();
    run_random(600, 30, 10);

    reset_assert();
    reset_release();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
